// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types and hex segment table for the seven-segment scan driver
package seg7_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHOW,
        GAP
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    // Segment order {g,f,e,d,c,b,a}; entry 15 is listed first.
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - result word valid/ready handshake between result stage and display
interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic                  res_valid;
    logic                  res_ready;
    logic [4*DIGITS-1:0]   res_data;

    modport master (output res_valid, output res_data, input res_ready);
    modport slave  (input res_valid, input res_data, output res_ready);
endinterface

// File: rtl/seg7_hex_decode.sv
// rtl/seg7_hex_decode.sv - combinational 4-bit hex to seven-segment lookup
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);
    assign seg = HEX_SEG[nibble];
endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - double-buffered multiplexed seven-segment scan driver
// Optional leading-zero suppression: define SEG7_LZ_BLANK_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 16
) (
    input  logic                clk,
    input  logic                rst,
    seg7_scan_driver_if.slave   res,
    output logic [6:0]          seg,
    output logic [DIGITS-1:0]   dig_en,
    output logic                frame_done
);
    localparam int DIG_W = $clog2(DIGITS);
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    state_t                 state;
    logic [4*DIGITS-1:0]    shadow;
    logic [4*DIGITS-1:0]    active;
    logic                   pending;
    logic [DIG_W-1:0]       digit;
    logic [CNT_W-1:0]       cnt;
    logic                   wrap_q;
    logic [6:0]             dec_seg;
    logic                   lz_blank;

    assign res.res_ready = !pending;

    seg7_hex_decode u_decode (
        .nibble (active[4*digit +: 4]),
        .seg    (dec_seg)
    );

`ifdef SEG7_LZ_BLANK_EN
    // zero_from[k]: nibbles k..DIGITS-1 of the displayed word are all zero.
    logic [DIGITS-1:0] zero_from;
    always_comb begin
        zero_from = '0;
        zero_from[DIGITS-1] = (active[4*(DIGITS-1) +: 4] == 4'h0);
        for (int k = DIGITS - 2; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] && (active[4*k +: 4] == 4'h0);
        end
    end
    assign lz_blank = (digit != '0) && zero_from[digit];
`else
    assign lz_blank = 1'b0;
`endif

    // Outputs are registered from the current state, so they trail it by one
    // cycle; frame_done is delayed through wrap_q to stay aligned with them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            shadow     <= '0;
            active     <= '0;
            pending    <= 1'b0;
            digit      <= '0;
            cnt        <= '0;
            wrap_q     <= 1'b0;
            seg        <= SEG_BLANK;
            dig_en     <= '0;
            frame_done <= 1'b0;
        end else begin
            if (res.res_valid && !pending) begin
                shadow  <= res.res_data;
                pending <= 1'b1;
            end
            wrap_q     <= 1'b0;
            frame_done <= wrap_q;
            seg        <= SEG_BLANK;
            dig_en     <= '0;
            case (state)
                IDLE: begin
                    if (pending) begin
                        active  <= shadow;
                        pending <= 1'b0;
                        digit   <= '0;
                        cnt     <= '0;
                        state   <= SHOW;
                    end
                end
                SHOW: begin
                    dig_en <= {{(DIGITS-1){1'b0}}, 1'b1} << digit;
                    seg    <= lz_blank ? SEG_BLANK : dec_seg;
                    if (cnt == CNT_LAST) begin
                        cnt   <= '0;
                        state <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    state <= SHOW;
                    if (digit == DIG_LAST) begin
                        digit  <= '0;
                        wrap_q <= 1'b1;
                        if (pending) begin
                            active  <= shadow;
                            pending <= 1'b0;
                        end
                    end else begin
                        digit <= digit + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - scoreboard bench for seg7_scan_driver (DIGITS=4, PRESCALE=4)
module tb_seg7_scan_driver;
    localparam int DIGITS   = 4;
    localparam int PRESCALE = 4;
    localparam int FRAME    = DIGITS * (PRESCALE + 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(DIGITS)) rif ();
    logic [6:0]        seg;
    logic [DIGITS-1:0] dig_en;
    logic              frame_done;

    seg7_scan_driver #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk        (clk),
        .rst        (rst),
        .res        (rif),
        .seg        (seg),
        .dig_en     (dig_en),
        .frame_done (frame_done)
    );

    typedef struct {
        logic [15:0] data;
        int          acc;
    } word_t;

    word_t       words[$];
    logic [11:0] exp_q[$];
    logic [15:0] cur = '0;
    int          cyc = 0;
    int          frames = 0;
    bit          running = 0;
    bit          expect_dark = 0;
    int          n_checks = 0;
    int          n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [6:0] exp_seg(input logic [15:0] w, input int d);
        logic [15:0] sh;
        logic [3:0]  nib;
        sh  = w >> (4 * d);
        nib = sh[3:0];
`ifdef SEG7_LZ_BLANK_EN
        if (d > 0 && sh == 16'h0) return 7'h00;
`endif
        case (nib)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // A word accepted at edge A is shown in a frame that starts at least two edges later.
    task automatic start_frame(input bit first);
        logic [3:0] en;
        if (words.size() > 0 && words[0].acc <= cyc - 3) begin
            cur = words[0].data;
            void'(words.pop_front());
        end
        frames++;
        for (int d = 0; d < DIGITS; d++) begin
            en = 4'b0001 << d;
            for (int c = 0; c <= PRESCALE; c++) begin
                if (c < PRESCALE)
                    exp_q.push_back({(d == 0 && c == 0 && !first), en, exp_seg(cur, d)});
                else
                    exp_q.push_back(12'h000);
            end
        end
    endtask

    always @(posedge clk) begin
        if (!rst && rif.res_valid && rif.res_ready) words.push_back('{rif.res_data, cyc});
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        logic [11:0] e;
        if (rst) begin
            running = 0;
            exp_q.delete();
            words.delete();
        end else begin
            if (expect_dark) check_eq("dark", {20'h0, frame_done, dig_en, seg}, 32'h0);
            if (!running && dig_en != '0) begin
                running = 1;
                start_frame(1);
            end else if (running && exp_q.size() == 0) begin
                start_frame(0);
            end
            if (running) begin
                e = exp_q.pop_front();
                check_eq("scan", {20'h0, frame_done, dig_en, seg}, {20'h0, e});
            end
        end
    end

    task automatic send(input logic [15:0] w, input bit scramble);
        int waited = 0;
        bit done = 0;
        @(posedge clk);
        #1;
        rif.res_valid = 1'b1;
        rif.res_data  = w;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (rif.res_ready) begin
                @(posedge clk);
                #1;
                done = 1;
            end else begin
                waited++;
                @(posedge clk);
                #1;
                if (scramble) rif.res_data = 16'($urandom);
            end
        end
        rif.res_valid = 1'b0;
        if (!done) check_eq("send_timeout", 32'd0, 32'd1);
        if (scramble) check_eq("holdoff", {31'h0, waited > 0}, 32'd1);
    endtask

    initial begin
        bit found;
        rif.res_valid = 1'b0;
        rif.res_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_seg", {25'h0, seg}, 32'h0);
        check_eq("rst_dig_en", {28'h0, dig_en}, 32'h0);
        check_eq("rst_frame_done", {31'h0, frame_done}, 32'h0);
        check_eq("rst_ready", {31'h0, rif.res_ready}, 32'h1);
        #1 rst = 1'b0;
        expect_dark = 1;
        repeat (100) @(negedge clk);
        check_eq("idle_ready", {31'h0, rif.res_ready}, 32'h1);
        expect_dark = 0;

        // First word from IDLE: pending for one cycle, lit two edges after the handshake.
        @(posedge clk);
        #1;
        rif.res_valid = 1'b1;
        rif.res_data  = 16'h1A08;
        @(posedge clk);
        #1 rif.res_valid = 1'b0;
        @(negedge clk);
        check_eq("lat_ready_t", {31'h0, rif.res_ready}, 32'h0);
        check_eq("lat_dark_t", {28'h0, dig_en}, 32'h0);
        @(negedge clk);
        check_eq("lat_ready_t1", {31'h0, rif.res_ready}, 32'h1);
        check_eq("lat_dark_t1", {28'h0, dig_en}, 32'h0);
        @(negedge clk);
        check_eq("lat_dig_t2", {28'h0, dig_en}, 32'h1);
        check_eq("lat_seg_t2", {25'h0, seg}, 32'h7F);
        repeat (3 * FRAME) @(negedge clk);

        // Double buffering: the second word waits for the wrap of the first.
        send(16'h1234, 0);
        @(negedge clk);
        check_eq("pend_ready", {31'h0, rif.res_ready}, 32'h0);
        send(16'h5678, 0);
        repeat (2 * FRAME + 7) @(negedge clk);
        send(16'h9ABC, 0);
        send(16'hFFFF, 1);
        repeat (3 * FRAME) @(negedge clk);

        // Asynchronous reset while digit 2 is lit.
        found = 0;
        for (int i = 0; i < 4 * FRAME && !found; i++) begin
            @(negedge clk);
            if (dig_en == 4'b0100) found = 1;
        end
        check_eq("find_digit2", {31'h0, found}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check_eq("async_seg", {25'h0, seg}, 32'h0);
        check_eq("async_dig_en", {28'h0, dig_en}, 32'h0);
        check_eq("async_ready", {31'h0, rif.res_ready}, 32'h1);
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        expect_dark = 1;
        repeat (30) @(negedge clk);
        expect_dark = 0;

        // Leading zeros: blanked only when SEG7_LZ_BLANK_EN is defined.
        send(16'h0050, 0);
        repeat (2 * FRAME + 5) @(negedge clk);
        send(16'hE00D, 0);
        repeat (2 * FRAME + 3) @(negedge clk);

        check_eq("frames_seen", {31'h0, frames >= 16}, 32'h1);
        check_eq("scoreboard_drained", {31'h0, words.size() == 0}, 32'h1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
